// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue slice: ALU control codes, the
// opcodes the decoder recognises and the issue FSM state type.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of RISC-V R/I-type integer ALU instructions into
// the 4-bit ALU control code plus legality and set-less-than flags.
// Optional feature macro: ALU_ISSUE_SLT_EN (enables SLT/SLTU decode).
module alu_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] control,
  output logic       legal,
  output logic       is_slt,
  output logic       is_sltu
);

  logic is_r;
  logic is_i;
  logic f7_base;
  logic f7_alt;

  assign is_r    = (opcode == OP_R);
  assign is_i    = (opcode == OP_I);
  assign f7_base = (funct7 == F7_BASE);
  assign f7_alt  = (funct7 == F7_ALT);

  // Map funct3/funct7 to a control code; I-type ignores funct7 except for shifts
  always_comb begin
    control = ALU_ADD;
    legal   = 1'b0;
    is_slt  = 1'b0;
    is_sltu = 1'b0;
    if (is_r || is_i) begin
      case (funct3)
        3'b000: begin
          if (is_r && f7_alt) begin
            control = ALU_SUB;
            legal   = 1'b1;
          end else if (is_i || f7_base) begin
            control = ALU_ADD;
            legal   = 1'b1;
          end
        end
        3'b001: begin
          control = ALU_SLL;
          legal   = f7_base;
        end
        3'b100: begin
          control = ALU_XOR;
          legal   = is_i || f7_base;
        end
        3'b101: begin
          if (f7_base) begin
            control = ALU_SRL;
            legal   = 1'b1;
          end else if (f7_alt) begin
            control = ALU_SRA;
            legal   = 1'b1;
          end
        end
        3'b110: begin
          control = ALU_OR;
          legal   = is_i || f7_base;
        end
        3'b111: begin
          control = ALU_AND;
          legal   = is_i || f7_base;
        end
`ifdef ALU_ISSUE_SLT_EN
        3'b010: begin
          control = ALU_SUB;
          legal   = is_i || f7_base;
          is_slt  = is_i || f7_base;
        end
        3'b011: begin
          control = ALU_SUB;
          legal   = is_i || f7_base;
          is_sltu = is_i || f7_base;
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Sequential initiator for the 32-bit combinational ALU: accepts one
// request, drives the ALU from registered control/operands, captures the
// result and returns it over a valid/ready response handshake.
// Optional feature macro: ALU_ISSUE_SLT_EN (SLT/SLTU via ALU subtract).
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_c,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_err
);

  state_t state;
  state_t state_next;

  logic [3:0] dec_control;
  logic       dec_legal;
  logic       dec_slt;
  logic       dec_sltu;
  logic       slt_q;
  logic       sltu_q;
  logic       lt;
  logic       accept;

  alu_decode u_decode (
    .opcode  (in_opcode),
    .funct3  (in_funct3),
    .funct7  (in_funct7),
    .control (dec_control),
    .legal   (dec_legal),
    .is_slt  (dec_slt),
    .is_sltu (dec_sltu)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_RESP);
  assign accept    = in_valid && in_ready;

  // Less-than from the ALU difference; on differing sign bits the
  // subtraction may overflow, so the answer comes from the operand signs
  always_comb begin
    lt = alu_c[XLEN-1];
    if (alu_a[XLEN-1] ^ alu_b[XLEN-1]) begin
      lt = sltu_q ? alu_b[XLEN-1] : alu_a[XLEN-1];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: illegal requests skip EXEC and respond directly
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = dec_legal ? ST_EXEC : ST_RESP;
        end
      end
      ST_EXEC: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: ALU drive registers load only on a legal accept, response
  // registers load on an illegal accept or at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_control <= ALU_AND;
      alu_a       <= '0;
      alu_b       <= '0;
      slt_q       <= 1'b0;
      sltu_q      <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (dec_legal) begin
              alu_control <= dec_control;
              alu_a       <= in_a;
              alu_b       <= in_b;
              slt_q       <= dec_slt;
              sltu_q      <= dec_sltu;
            end else begin
              out_result <= '0;
              out_zero   <= 1'b1;
              out_err    <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (slt_q || sltu_q) begin
            out_result <= {{(XLEN-1){1'b0}}, lt};
            out_zero   <= !lt;
          end else begin
            out_result <= alu_c;
            out_zero   <= alu_zero;
          end
          out_err <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
